sdpram_lut_reader: RTL
======================

# sdpram_lut_reader

Read-side engine for the 48×32 LUT-based simple dual-port RAM.
- Accepts a burst command: start address plus word count.
- Drives the RAM read port (enb/addrb) and captures the zero-latency doutb into a registered output stage.
- Emits words on a valid/ready stream with a last-word flag, wrapping the address at the memory depth.
- Sits between the RAM read port and downstream consumers; the write port stays owned by the producer.

## Interface
- DATA_W, 32, RAM word width
- ADDR_W, 6, RAM address width
- DEPTH, 48, number of valid RAM entries; addresses 0..DEPTH-1
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  word count minus one (0 → 1 word, DEPTH-1 → DEPTH words)
- cmd_err  out  1  one-cycle pulse when a command is rejected
- ram_enb  out  1  RAM port-B enable
- ram_addrb  out  ADDR_W  RAM port-B address, always equal to the internal pointer
- ram_doutb  in  DATA_W  RAM read data, combinational from ram_addrb (latency 0)
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  output word, registered
- m_last  out  1  marks the final word of the burst
- busy  out  1  high in READ or DRAIN

## Operation
- FSM states: IDLE, READ, DRAIN.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid with cmd_addr<DEPTH and cmd_len<DEPTH: ptr←cmd_addr, remaining←cmd_len, go to READ.
  - On cmd_valid with cmd_addr≥DEPTH or cmd_len≥DEPTH: cmd_err pulses for 1 cycle, no state change, nothing emitted.
- **READ**
  - load = !m_valid || m_ready; ram_enb=load.
  - On load:
    - m_data←ram_doutb, m_valid←1, m_last←(remaining==0).
    - ptr←(ptr==DEPTH-1)?0:ptr+1.
    - remaining←remaining-1.
  - The load with remaining==0 moves the FSM to DRAIN.
- **DRAIN**
  - ram_enb=0; ptr holds.
  - On m_valid&&m_ready, m_valid←0 and the FSM returns to IDLE.
- Output register:
  - If m_valid&&m_ready and no load, m_valid←0.
  - m_data and m_last hold while m_valid&&!m_ready (no data change under backpressure).
- Wrap: address sequence …46,47,0,1…; a 48-word burst starting at 0 reads every entry exactly once.
- Arithmetic: ptr and remaining are ADDR_W unsigned; remaining never underflows because the FSM leaves READ at 0.
- Write collision: the block does no arbitration. A same-cycle write to ram_addrb returns the pre-write contents (read-first); the new data is visible from the next cycle.
- Reset, asynchronous, any state, including mid-burst:
  - State→IDLE; ptr=0, remaining=0.
  - m_valid=0, m_last=0, m_data=0, ram_enb=0, cmd_err=0.
  - The in-flight burst is abandoned and nothing further is emitted.

## Timing
- Command handshake at edge E0 → READ during the following cycle → first word has m_valid=1 after edge E1.
- Command-to-first-word latency: 2 cycles.
- With m_ready held high: 1 word/cycle. An N-word burst finishes its final handshake N+1 cycles after E0. The next cmd_ready rises the cycle after that handshake.
- m_ready low stalls the pointer and ram_enb the same cycle; no words are lost or duplicated.
- cmd_ready is combinational from state; cmd_err and all m_* outputs are registered.
- Reset values: cmd_ready=1 after reset release, busy=0, and all other outputs 0.

## Test plan
- Preload RAM[i]=0xA000_0000+i. Command addr=5, len=3, m_ready=1 → m_data 0xA0000005..08 on 4 consecutive cycles; m_last only on 0xA0000008; first m_valid 2 cycles after the command.
- Command addr=46, len=3 → words from addresses 46,47,0,1 in order; m_last on address 1.
- Command addr=0, len=47, with m_ready toggling 1,0,0,1 pseudo-randomly → exactly 48 words, values 0..47 in order, none repeated; m_data stable while stalled.
- Command addr=48 or len=50 → cmd_err pulses exactly 1 cycle; m_valid stays 0; FSM stays IDLE.
- Assert rst_n=0 after the third word of a 10-word burst → m_valid, busy and ram_enb are 0 immediately. After release, cmd_ready=1 and a new command addr=0, len=0 returns a single word with m_last=1.
- Producer writes 0xDEAD_BEEF to address 7 in the same cycle the reader reads address 7 → old value emitted; a re-read of address 7 returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/sdpram_lut_reader_if.sv
// Bundle of the reader's command, RAM read-port and output-stream signals.
// master = the reader engine; slave = the surrounding RAM/producer/consumer side.
interface sdpram_lut_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              cmd_err;
    logic              ram_enb;
    logic [ADDR_W-1:0] ram_addrb;
    logic [DATA_W-1:0] ram_doutb;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_doutb, m_ready,
        output cmd_ready, cmd_err, ram_enb, ram_addrb, m_valid, m_data, m_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_doutb, m_ready,
        input  cmd_ready, cmd_err, ram_enb, ram_addrb, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/sdpram_lut_reader.sv
// Burst read engine for a zero-latency LUT RAM: walks a wrapping address range
// and streams the words through a single registered valid/ready output stage.
module sdpram_lut_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 48
) (
    input logic                 clk,
    input logic                 rst_n,
    sdpram_lut_reader_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] remaining;
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] out_data;
    logic              err_pulse;
    logic              load;
    logic              cmd_ok;

    // Compare at 32 bits so the range check stays correct for any DEPTH.
    assign cmd_ok = (int'(bus.cmd_addr) < DEPTH) && (int'(bus.cmd_len) < DEPTH);

    // A read fires whenever the output register is empty or being drained this cycle.
    assign load = (state == S_READ) && (!out_valid || bus.m_ready);

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state == S_READ) || (state == S_DRAIN);
    assign bus.ram_enb   = load;
    assign bus.ram_addrb = ptr;
    assign bus.m_valid   = out_valid;
    assign bus.m_data    = out_data;
    assign bus.m_last    = out_last;
    assign bus.cmd_err   = err_pulse;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, matching the zero-latency RAM read that feeds out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (cmd_ok) begin
                            ptr       <= bus.cmd_addr;
                            remaining <= bus.cmd_len;
                            state     <= S_READ;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (load) begin
                        ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
                        if (remaining == '0) begin
                            state <= S_DRAIN;
                        end else begin
                            remaining <= remaining - ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid && bus.m_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output stage: data and last only change on a load, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= (remaining == '0);
            out_data  <= bus.ram_doutb;
        end else if (out_valid && bus.m_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
